conv2d_stream_engine: RTL and testbench

//  Parametrised successor to the fixed 32x32 Sobel-X conv engine: streams a raster image, applies a 3x3 kernel
//  (Sobel X, Sobel Y or run-time programmable) and emits valid-region results in raster order.

---
 rtl/conv2d_stream_engine_pkg.sv | 8 +
 rtl/conv2d_stream_engine_line_buffer.sv | 21 ++
 rtl/conv2d_stream_engine.sv | 113 +++++++++++
 tb/tb_conv2d_stream_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_stream_engine_pkg.sv
// conv2d_stream_engine_pkg: Sobel coefficient tables plus the kernel, post-processing and FSM state enums
package conv2d_stream_engine_pkg;
  typedef enum logic [1:0] {KSEL_X, KSEL_Y, KSEL_CUSTOM, KSEL_RSVD} kernel_sel_e;
  typedef enum logic [1:0] {POST_RAW, POST_RELU, POST_ABS, POST_RSVD} post_mode_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} conv_state_e;
  localparam int SOBEL_X [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  localparam int SOBEL_Y [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
endpackage

// File: rtl/conv2d_stream_engine_line_buffer.sv
// conv_line_buffer: DEPTH-deep shift register delaying pixels by one image row; ports clk, rst, push, din in, dout out
module conv_line_buffer #(
  parameter int DEPTH = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) mem <= '{default: '0};
    else if (push) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end
  assign dout = mem[DEPTH-1];
endmodule

// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: streaming 3x3 convolution with config latch on start_signal, pixel valid/ready in, result valid/ready out, done_signal pulse
module conv2d_stream_engine
  import conv2d_stream_engine_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int PIX_W = 8,
  parameter int COEF_W = 8,
  localparam int ACC_W = PIX_W + COEF_W + 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_signal,
  input  logic [1:0]              kernel_sel,
  input  logic [1:0]              post_mode,
  input  logic [9*COEF_W-1:0]     coef_in,
  input  logic                    pixel_valid,
  input  logic [PIX_W-1:0]        pixel_in,
  output logic                    pixel_ready,
  output logic signed [ACC_W-1:0] result_out,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    done_signal
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  conv_state_e state, state_n;
  post_mode_e post;
  logic signed [COEF_W-1:0] coef [9];
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic fed, accept, load, last_px, x_end, begin_frame;
  logic [PIX_W-1:0] c0 [3];
  logic [PIX_W-1:0] c1 [3];
  logic [PIX_W-1:0] col [3];
  logic [PIX_W-1:0] lb1, lb2;
  logic signed [ACC_W-1:0] acc, post_val;

  function automatic logic signed [ACC_W-1:0] mul(input logic [PIX_W-1:0] p, input logic signed [COEF_W-1:0] k);
    return ACC_W'($signed({1'b0, p})) * ACC_W'(k);
  endfunction

  assign begin_frame = state == IDLE && start_signal;
  assign pixel_ready = state == RUN && !fed && (!result_valid || result_ready);
  assign accept = pixel_valid && pixel_ready;
  assign x_end = x == XW'(IMG_W - 1);
  assign last_px = x_end && y == YW'(IMG_H - 1);
  assign load = accept && x >= XW'(2) && y >= YW'(2);
  assign done_signal = state == DONE;
  // newest window column, top row (y-2) first
  assign col = '{lb2, lb1, pixel_in};

  conv_line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) lb_a (
    .clk(clk), .rst(rst), .push(accept), .din(pixel_in), .dout(lb1)
  );
  conv_line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) lb_b (
    .clk(clk), .rst(rst), .push(accept), .din(lb1), .dout(lb2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) coef[k] <= COEF_W'(SOBEL_X[k]);
      post <= POST_RAW;
    end else if (begin_frame) begin
      for (int k = 0; k < 9; k++)
        coef[k] <= kernel_sel_e'(kernel_sel) == KSEL_Y ? COEF_W'(SOBEL_Y[k]) :
                   kernel_sel_e'(kernel_sel) == KSEL_CUSTOM ? coef_in[k*COEF_W +: COEF_W] : COEF_W'(SOBEL_X[k]);
      post <= post_mode_e'(post_mode);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || begin_frame) begin
      x <= '0;
      y <= '0;
      fed <= 1'b0;
      c0 <= '{default: '0};
      c1 <= '{default: '0};
    end else if (accept) begin
      x <= x_end ? '0 : x + 1'b1;
      y <= x_end ? y + 1'b1 : y;
      fed <= last_px;
      c0 <= c1;
      c1 <= col;
    end
  end

  // reserved post mode falls through to raw
  always_comb begin
    acc = '0;
    for (int r = 0; r < 3; r++)
      acc += mul(c0[r], coef[3*r]) + mul(c1[r], coef[3*r+1]) + mul(col[r], coef[3*r+2]);
    post_val = post == POST_RELU && acc < 0 ? '0 : post == POST_ABS && acc < 0 ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_out <= '0;
      result_valid <= 1'b0;
    end else if (load) begin
      result_out <= post_val;
      result_valid <= 1'b1;
    end else if (result_ready) result_valid <= 1'b0;
  end

  // once the last pixel is in, the next handshake is the final result
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;

  always_comb begin
    state_n = state == IDLE ? (start_signal ? RUN : IDLE) :
              state == RUN ? (fed && result_valid && result_ready ? DONE : RUN) : IDLE;
  end
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// tb_conv2d_stream_engine: randomized scoreboard bench for conv2d_stream_engine at 32x32 and 8x5
module tb_conv2d_stream_engine;
  localparam int W = 32, H = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, pv = 1'b0, pr, rv, rrdy = 1'b1, done;
  logic [1:0] ksel = '0, pmode = '0;
  logic [71:0] coef = '0;
  logic [7:0] pin = '0;
  logic [21:0] ro;
  logic b_start = 1'b0, b_pv = 1'b0, b_pr, b_rv, b_rr = 1'b1, b_done;
  logic [1:0] b_ksel = '0, b_pmode = '0;
  logic [71:0] b_coef = '0;
  logic [7:0] b_pin = '0;
  logic [21:0] b_ro;

  int n_cmp = 0, n_bad = 0, done_cnt = 0, b_done_cnt = 0;
  int q[$], bq[$];
  int img[W*H];
  int kx[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int ky[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
  logic rr_rand = 1'b0;

  conv2d_stream_engine dut (
    .clk(clk), .rst(rst), .start_signal(start), .kernel_sel(ksel), .post_mode(pmode), .coef_in(coef),
    .pixel_valid(pv), .pixel_in(pin), .pixel_ready(pr), .result_out(ro), .result_valid(rv),
    .result_ready(rrdy), .done_signal(done)
  );

  conv2d_stream_engine #(.IMG_W(8), .IMG_H(5)) dut_b (
    .clk(clk), .rst(rst), .start_signal(b_start), .kernel_sel(b_ksel), .post_mode(b_pmode), .coef_in(b_coef),
    .pixel_valid(b_pv), .pixel_in(b_pin), .pixel_ready(b_pr), .result_out(b_ro), .result_valid(b_rv),
    .result_ready(b_rr), .done_signal(b_done)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model(input int r, input int c, input int k[9], input int pm);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) s += img[(r+i)*W + c + j] * k[3*i+j];
    if (pm == 1 && s < 0) s = 0;
    if (pm == 2 && s < 0) s = -s;
    return s;
  endfunction

  initial forever begin
    @(posedge clk);
    #1 rrdy = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    logic stall = 1'b0;
    int held = 0;
    forever begin
      @(negedge clk);
      if (rst) stall = 1'b0;
      else begin
        if (done) done_cnt++;
        if (stall) begin
          chk("stall_valid", int'(rv), 1);
          chk("stall_hold", int'($signed(ro)), held);
        end
        if (rv && !rrdy) chk("stall_pixel_ready", int'(pr), 0);
        if (rv && rrdy) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_result: got %0d expected none", int'($signed(ro)));
          end else chk("result", int'($signed(ro)), q.pop_front());
        end
        stall = rv && !rrdy;
        held = int'($signed(ro));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (b_done) b_done_cnt++;
      if (b_rv && b_rr) begin
        if (bq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL b_extra_result: got %0d expected none", int'($signed(b_ro)));
        end else chk("b_result", int'($signed(b_ro)), bq.pop_front());
      end
    end
  end

  task automatic run_frame(input int pat, input logic [1:0] ks, input logic [1:0] pm, input logic gaps, input int abort_at);
    int kc[9], ke[9];
    int idx, cyc, d0, pme;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y*W+x] = pat == 0 ? (x < 16 ? 0 : 255) : pat == 1 ? ((x + y) % 2 == 0 ? 255 : 0) :
                     pat == 2 ? (y < 16 ? 0 : 255) : pat == 3 ? (x < 16 ? 255 : 0) : int'($urandom_range(0, 255));
    for (int k = 0; k < 9; k++) begin
      kc[k] = int'($urandom_range(0, 255)) - 128;
      coef[k*8 +: 8] = 8'(kc[k]);
      ke[k] = ks == 2'd1 ? ky[k] : ks == 2'd2 ? kc[k] : kx[k];
    end
    pme = pm == 2'd3 ? 0 : int'(pm);
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++) q.push_back(model(r, c, ke, pme));
    d0 = done_cnt;
    rr_rand = gaps;
    @(posedge clk);
    #1 start = 1'b1;
    ksel = ks;
    pmode = pm;
    @(posedge clk);
    #1 start = 1'b0;
    ksel = 2'($urandom);
    pmode = 2'($urandom);
    coef = {$urandom, $urandom, $urandom};
    idx = 0;
    cyc = 0;
    while (idx < W*H && cyc < 20000) begin
      pv = gaps ? $urandom_range(0, 2) != 0 : 1'b1;
      pin = 8'(img[idx]);
      start = gaps && idx == 300;
      @(negedge clk);
      if (pv && pr) idx++;
      cyc++;
      if (abort_at > 0 && idx == abort_at) break;
      @(posedge clk);
      #1;
    end
    if (abort_at > 0) begin
      @(posedge clk);
      #1 pv = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 q.delete();
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_valid", int'(rv), 0);
      chk("abort_pixel_ready", int'(pr), 0);
      return;
    end
    #1 pv = 1'b0;
    start = 1'b0;
    chk("pixels_accepted", idx, W*H);
    cyc = 0;
    while (done_cnt == d0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    chk("done_count", done_cnt - d0, 1);
    chk("results_left", q.size(), 0);
    chk("idle_valid", int'(rv), 0);
    q.delete();
  endtask

  initial begin
    int idx, cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", int'(rv), 0);
    chk("reset_result", int'(ro), 0);
    chk("reset_pixel_ready", int'(pr), 0);
    chk("reset_done", int'(done), 0);
    #1 rst = 1'b0;
    pv = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_pixel_ready", int'(pr), 0);
    pv = 1'b0;
    run_frame(0, 2'd0, 2'd0, 1'b0, 0);
    run_frame(1, 2'd0, 2'd0, 1'b0, 0);
    run_frame(2, 2'd1, 2'd0, 1'b0, 0);
    run_frame(3, 2'd0, 2'd1, 1'b0, 0);
    run_frame(3, 2'd0, 2'd2, 1'b0, 0);
    run_frame(4, 2'd2, 2'($urandom_range(0, 2)), 1'b0, 0);
    run_frame(4, 2'd2, 2'd2, 1'b1, 0);
    run_frame(0, 2'd3, 2'd3, 1'b0, 0);
    run_frame(0, 2'd0, 2'd0, 1'b1, 0);
    run_frame(1, 2'd0, 2'd0, 1'b1, 500);
    run_frame(1, 2'd0, 2'd0, 1'b0, 0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 6; c++) bq.push_back(9 * (c + 1 + 8 * (r + 1)));
    for (int k = 0; k < 9; k++) b_coef[k*8 +: 8] = 8'd1;
    @(posedge clk);
    #1 b_start = 1'b1;
    b_ksel = 2'd2;
    @(posedge clk);
    #1 b_start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 40 && cyc < 1000) begin
      b_pv = 1'b1;
      b_pin = 8'(idx);
      @(negedge clk);
      if (b_pv && b_pr) idx++;
      cyc++;
      @(posedge clk);
      #1;
    end
    b_pv = 1'b0;
    chk("b_pixels_accepted", idx, 40);
    cyc = 0;
    while (b_done_cnt == 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    chk("b_done_count", b_done_cnt, 1);
    chk("b_results_left", bq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
